// File: rtl/vga_text_fetch_if.sv
// Memory-side bus of the text fetch stage: VRAM word port and font glyph port,
// both plain address-out / data-in with a fixed one-cycle read latency.
`timescale 1ns/1ps
interface vga_text_fetch_if #(
    parameter int VRAM_AW = 12
);
    logic [VRAM_AW-1:0] vram_adr_o;
    logic [15:0]        vram_dat_i;
    logic [11:0]        font_adr_o;
    logic [7:0]         font_dat_i;

    modport master (
        output vram_adr_o,
        output font_adr_o,
        input  vram_dat_i,
        input  font_dat_i
    );

    modport slave (
        input  vram_adr_o,
        input  font_adr_o,
        output vram_dat_i,
        output font_dat_i
    );
endinterface

// File: rtl/vga_text_fetch.sv
// Text-mode pixel generator behind the VGA CRTC: strictly periodic VRAM/font fetch,
// 8-dot serialiser with cursor and blink, sync/enable realigned to a 5-cycle latency.
`timescale 1ns/1ps
module vga_text_fetch #(
    parameter int COLS    = 80,
    parameter int VRAM_AW = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [9:0]         h_count,
    input  logic [9:0]         v_count,
    input  logic               horiz_sync_i,
    input  logic               video_on_h_i,
    input  logic               video_on_v,
    input  logic [VRAM_AW-1:0] start_addr,
    input  logic [5:0]         cur_start,
    input  logic [5:0]         cur_end,
    input  logic [4:0]         vcursor,
    input  logic [6:0]         hcursor,
    input  logic               blink_en,
    vga_text_fetch_if.master   mem,
    output logic [3:0]         color_o,
    output logic               video_on_o,
    output logic               horiz_sync_o
);
    localparam int          DELAY   = 5;
    localparam logic [2:0]  K_ADDR  = 3'd0;
    localparam logic [2:0]  K_CHAR  = 3'd2;
    localparam logic [2:0]  K_GLYPH = 3'd4;

    logic [6:0] column;
    logic [2:0] sub_k;
    logic [4:0] row;
    logic [3:0] scanline;

    assign column   = h_count[9:3];
    assign sub_k    = h_count[2:0];
    assign row      = v_count[8:4];
    assign scanline = v_count[3:0];

    logic unused_bits;
    assign unused_bits = ^{v_count[9], cur_end[5]};

    // Character address: start + row*COLS + column, wrapping in the VRAM address space.
    logic [VRAM_AW-1:0] row_w, col_w, row_off;
    assign row_w = VRAM_AW'(row);
    assign col_w = VRAM_AW'(column);

    generate
        if (COLS == 80) begin : g_shift_add
            assign row_off = (row_w << 6) + (row_w << 4);
        end else begin : g_mul
            assign row_off = row_w * VRAM_AW'(COLS);
        end
    endgenerate

    logic [VRAM_AW-1:0] vram_adr_q, vram_adr_d;
    logic [11:0]        font_adr_q, font_adr_d;
    logic [7:0]         attr_q, attr_d;
    logic               hit_q, hit_d;
    logic [7:0]         attr_out_q, attr_out_d;
    logic               hit_out_q, hit_out_d;
    logic [7:0]         shifter_q, shifter_d;
    logic [4:0]         blink_cnt_q, blink_cnt_d;
    logic [DELAY-1:0]   video_dly_q, video_dly_d;
    logic [DELAY-1:0]   sync_dly_q, sync_dly_d;
    logic               cursor_hit;

    // An inverted scanline window (start > end) matches no scanline, so it needs no extra term.
    assign cursor_hit = !cur_start[5]
                     && (row == vcursor)
                     && (column == hcursor)
                     && (cur_start[4:0] <= {1'b0, scanline})
                     && ({1'b0, scanline} <= cur_end[4:0])
                     && !blink_cnt_q[4];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        vram_adr_d  = vram_adr_q;
        font_adr_d  = font_adr_q;
        attr_d      = attr_q;
        hit_d       = hit_q;
        attr_out_d  = attr_out_q;
        hit_out_d   = hit_out_q;
        shifter_d   = {shifter_q[6:0], 1'b0};
        blink_cnt_d = blink_cnt_q;
        video_dly_d = {video_dly_q[DELAY-2:0], video_on_h_i & video_on_v};
        sync_dly_d  = {sync_dly_q[DELAY-2:0], horiz_sync_i};

        case (sub_k)
            K_ADDR: vram_adr_d = start_addr + row_off + col_w;
            K_CHAR: begin
                attr_d     = mem.vram_dat_i[15:8];
                font_adr_d = {mem.vram_dat_i[7:0], scanline};
                hit_d      = cursor_hit;
            end
            K_GLYPH: begin
                shifter_d  = mem.font_dat_i;
                attr_out_d = attr_q;
                hit_out_d  = hit_q;
            end
            default: ;
        endcase

        if (v_count == 10'd0 && h_count == 10'd0) begin
            blink_cnt_d = blink_cnt_q + 5'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            vram_adr_q  <= '0;
            font_adr_q  <= '0;
            attr_q      <= '0;
            hit_q       <= 1'b0;
            attr_out_q  <= '0;
            hit_out_q   <= 1'b0;
            shifter_q   <= '0;
            blink_cnt_q <= '0;
            video_dly_q <= '0;
            sync_dly_q  <= '1;
        end else if (enable) begin
            vram_adr_q  <= vram_adr_d;
            font_adr_q  <= font_adr_d;
            attr_q      <= attr_d;
            hit_q       <= hit_d;
            attr_out_q  <= attr_out_d;
            hit_out_q   <= hit_out_d;
            shifter_q   <= shifter_d;
            blink_cnt_q <= blink_cnt_d;
            video_dly_q <= video_dly_d;
            sync_dly_q  <= sync_dly_d;
        end
    end

    assign mem.vram_adr_o = vram_adr_q;
    assign mem.font_adr_o = font_adr_q;

    logic blink_off;
    logic dot;

    assign blink_off = blink_en && attr_out_q[7] && blink_cnt_q[4];
    assign dot       = (shifter_q[7] | hit_out_q) & ~blink_off;

    assign video_on_o   = video_dly_q[DELAY-1];
    assign horiz_sync_o = sync_dly_q[DELAY-1];

    always_comb begin
        color_o = 4'h0;
        if (video_on_o) begin
            color_o = dot ? attr_out_q[3:0]
                          : {(blink_en ? 1'b0 : attr_out_q[7]), attr_out_q[6:4]};
        end
    end
endmodule

// File: tb/tb_vga_text_fetch.sv
// Directed bench for vga_text_fetch: stub VRAM/font with one-cycle latency, hand-computed
// pixel strings, sync delay, address arithmetic, cursor, blink, reset and enable freeze.
`timescale 1ns/1ps
module tb_vga_text_fetch;
    logic        clk;
    logic        rst;
    logic        enable;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic        horiz_sync_i;
    logic        video_on_h_i;
    logic        video_on_v;
    logic [11:0] start_addr;
    logic [5:0]  cur_start;
    logic [5:0]  cur_end;
    logic [4:0]  vcursor;
    logic [6:0]  hcursor;
    logic        blink_en;
    logic [3:0]  color_o;
    logic        video_on_o;
    logic        horiz_sync_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] vram [0:4095];
    logic [7:0]  font [0:4095];

    vga_text_fetch_if #(.VRAM_AW(12)) mem_if ();

    vga_text_fetch #(.COLS(80), .VRAM_AW(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .h_count      (h_count),
        .v_count      (v_count),
        .horiz_sync_i (horiz_sync_i),
        .video_on_h_i (video_on_h_i),
        .video_on_v   (video_on_v),
        .start_addr   (start_addr),
        .cur_start    (cur_start),
        .cur_end      (cur_end),
        .vcursor      (vcursor),
        .hcursor      (hcursor),
        .blink_en     (blink_en),
        .mem          (mem_if.master),
        .color_o      (color_o),
        .video_on_o   (video_on_o),
        .horiz_sync_o (horiz_sync_o)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Synchronous RAM stubs: data for an address is on the bus one cycle later.
    always @(posedge clk) begin
        mem_if.vram_dat_i <= vram[mem_if.vram_adr_o];
        mem_if.font_dat_i <= font[mem_if.font_adr_o];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one cell starting at h=base and collect the 8 pixels seen on cycles 5..12.
    task automatic run_cell(input logic [9:0] v, input logic [9:0] base,
                            output logic [31:0] pix, output logic von);
        pix     = '0;
        von     = 1'b1;
        v_count = v;
        for (int i = 0; i < 12; i++) begin
            h_count = base + 10'(i);
            tick();
            if (i >= 4) begin
                pix = {pix[27:0], color_o};
                von = von & video_on_o;
            end
        end
    endtask

    task automatic bump_frames(input int n);
        v_count = 10'd0;
        h_count = 10'd0;
        repeat (n) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pix;
        logic        von;
        int          n_low;
        int          first_low;
        int          last_low;

        rst          = 1'b1;
        enable       = 1'b1;
        h_count      = 10'd0;
        v_count      = 10'd0;
        horiz_sync_i = 1'b1;
        video_on_h_i = 1'b1;
        video_on_v   = 1'b1;
        start_addr   = 12'h000;
        cur_start    = 6'h20;
        cur_end      = 6'h00;
        vcursor      = 5'd0;
        hcursor      = 7'd0;
        blink_en     = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            vram[i] = 16'h0000;
            font[i] = 8'h00;
        end

        // Reset state
        repeat (3) tick();
        check("rst_color",    color_o,           4'h0);
        check("rst_video_on", video_on_o,        1'b0);
        check("rst_hsync",    horiz_sync_o,      1'b1);
        check("rst_vram_adr", mem_if.vram_adr_o, 12'h000);
        check("rst_font_adr", mem_if.font_adr_o, 12'h000);
        rst = 1'b0;

        // Basic cell: char 0x41 attr 0x1F, glyph 0xA5
        vram[0]          = 16'h1F41;
        font[12'h410]    = 8'hA5;
        run_cell(10'd0, 10'd0, pix, von);
        check("t1_pixels",   pix, 32'hF1F1_1F1F);
        check("t1_video_on", von, 1'b1);

        // Horizontal sync low on cycles 100..195 must leave low on 105..200
        v_count   = 10'd100;
        n_low     = 0;
        first_low = -1;
        last_low  = -1;
        for (int c = 0; c <= 210; c++) begin
            horiz_sync_i = !(c >= 100 && c <= 195);
            h_count      = 10'(c);
            tick();
            if (!horiz_sync_o) begin
                if (first_low < 0) first_low = c + 1;
                last_low = c + 1;
                n_low++;
            end
        end
        horiz_sync_i = 1'b1;
        check("t2_first_low", first_low, 105);
        check("t2_last_low",  last_low,  200);
        check("t2_low_count", n_low,     96);

        // Address arithmetic: row 2, scanline 5, column 3, start 0x010
        start_addr    = 12'h010;
        v_count       = 10'h025;
        vram[12'h0B3] = 16'h0742;
        h_count = 10'd24; tick();
        check("t3_vram_adr", mem_if.vram_adr_o, 12'h0B3);
        h_count = 10'd25; tick();
        h_count = 10'd26; tick();
        check("t3_font_adr", mem_if.font_adr_o, 12'h425);
        // Address wrap: 0xFFF + column 1
        start_addr = 12'hFFF;
        v_count    = 10'd0;
        h_count    = 10'd8; tick();
        check("t3_addr_wrap", mem_if.vram_adr_o, 12'h000);
        start_addr = 12'h000;

        // Cursor at row 0 col 0, scanlines 14..15, blank glyph, attr 0x07
        vram[0]   = 16'h0700;
        cur_start = 6'h0E;
        cur_end   = 6'h0F;
        run_cell(10'd14, 10'd0, pix, von);
        check("t4_cursor_sl14", pix, 32'h7777_7777);
        run_cell(10'd15, 10'd0, pix, von);
        check("t4_cursor_sl15", pix, 32'h7777_7777);
        run_cell(10'd13, 10'd0, pix, von);
        check("t4_no_cursor_sl13", pix, 32'h0000_0000);
        cur_start = 6'h2E;
        run_cell(10'd14, 10'd0, pix, von);
        check("t4_cursor_disabled", pix, 32'h0000_0000);
        cur_start = 6'h20;

        // Blink: counter is 1 here (one frame start seen since reset)
        blink_en      = 1'b1;
        vram[0]       = 16'h8C01;
        font[12'h011] = 8'hFF;
        run_cell(10'd1, 10'd0, pix, von);
        check("t5_blink_frame1", pix, 32'hCCCC_CCCC);
        bump_frames(15);
        run_cell(10'd1, 10'd0, pix, von);
        check("t5_blink_frame16", pix, 32'h0000_0000);
        bump_frames(15);
        run_cell(10'd1, 10'd0, pix, von);
        check("t5_blink_frame31", pix, 32'h0000_0000);
        bump_frames(1);
        run_cell(10'd1, 10'd0, pix, von);
        check("t5_blink_wrap0", pix, 32'hCCCC_CCCC);
        blink_en = 1'b0;
        vram[0]  = 16'h8C02;
        run_cell(10'd1, 10'd0, pix, von);
        check("t5_bg_intensity", pix, 32'h8888_8888);

        // Reset mid-cell at k=3, then enable freeze
        vram[0]       = 16'h8C03;
        font[12'h031] = 8'hF0;
        v_count       = 10'd1;
        for (int i = 0; i < 3; i++) begin
            h_count = 10'(i);
            tick();
        end
        rst     = 1'b1;
        h_count = 10'd3;
        tick();
        rst = 1'b0;
        check("t6_rst_color",    color_o,      4'h0);
        check("t6_rst_hsync",    horiz_sync_o, 1'b1);
        check("t6_rst_video_on", video_on_o,   1'b0);

        enable = 1'b0;
        for (int i = 4; i < 8; i++) begin
            h_count = 10'(i);
            tick();
        end
        check("t6_frz_color",    color_o,      4'h0);
        check("t6_frz_hsync",    horiz_sync_o, 1'b1);
        check("t6_frz_video_on", video_on_o,   1'b0);

        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            h_count = 10'(i);
            tick();
        end
        check("t6_blank_after_4", video_on_o, 1'b0);
        h_count = 10'd4; tick();
        check("t6_video_on_at_5", video_on_o, 1'b1);
        check("t6_pixel0",        color_o,    4'hC);
        for (int i = 5; i < 8; i++) begin
            h_count = 10'(i);
            tick();
        end
        enable = 1'b0;
        for (int i = 8; i < 12; i++) begin
            h_count = 10'(i);
            tick();
        end
        check("t6_hold_color",    color_o,    4'hC);
        check("t6_hold_video_on", video_on_o, 1'b1);
        enable  = 1'b1;
        h_count = 10'd8;
        tick();
        check("t6_resume_pixel4", color_o, 4'h8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
